multiple_transfer_sequencer: RTL
================================

// Module: multiple_transfer_sequencer
// PURPOSE
//  Decode-stage companion for Thumb LDM/STM/PUSH/POP. Sits directly downstream of the
//  multi-cycle detect flag (multiple_stable_odd): latches the instruction, then issues
//  one register transfer per cycle to the data-memory stage while holding fetch/decode
//  stalled, then issues the base-register writeback. Handles 16-bit encodings only.
// PARAMETERS
//  OFFSET_W  7   width of signed byte offsets (covers -36..+36)
//  SP_INDEX  13  register index used as base for PUSH/POP
// PORTS
//  clk                  in   1  clock, rising edge
//  rst_n                in   1  asynchronous active-low reset
//  instruction_from_mem in  32  fetched word; current Thumb halfword in [31:16]
//  is32_from_stage1     in   1  current instruction is 32-bit; blocks start
//  multiple_stable_odd  in   1  multi-cycle transfer detected (from detect logic)
//  issue_valid          in   1  decode slot holds a valid instruction this cycle
//  mem_ready            in   1  memory stage accepts the presented transfer
//  busy                 out  1  sequence in progress
//  stall_fetch          out  1  hold fetch/decode; start cycle plus every busy cycle
//  xfer_valid           out  1  transfer presented
//  xfer_reg             out  4  register index of transfer
//  xfer_is_load         out  1  1 = LDM/POP, 0 = STM/PUSH
//  xfer_base_reg        out  4  base register index (Rn, or SP_INDEX)
//  xfer_offset          out OFFSET_W  signed byte offset from base value
//  wb_valid             out  1  one-cycle base writeback strobe
//  wb_offset            out OFFSET_W  signed byte offset to add to base
//  pc_loaded            out  1  with done: POP included PC (branch required)
//  done                 out  1  one-cycle pulse, sequence finished
// BEHAVIOUR
//  Reset: state IDLE; every output 0; latched list/count cleared.
//  Decode (hw=[31:16]): L=hw[11]. LDM/STM: hw[15:11]=1100x, Rn=hw[10:8], list=hw[7:0].
//   PUSH/POP: hw[15:12]=1011, hw[10:9]=10, list=hw[7:0], extra bit hw[8] = R14 (PUSH)
//   or R15 (POP). N = popcount of 9-bit list (0..9).
//  Start: IDLE & issue_valid & multiple_stable_odd & ~is32_from_stage1. stall_fetch is
//   combinationally high in start cycle. Start conditions are ignored outside IDLE.
//  FSM: IDLE -> XFER (N>0) or WB (N=0); XFER -> WB after last accepted transfer;
//   WB -> IDLE. done pulses in the WB cycle. busy=1 in XFER and WB.
//  XFER: xfer_valid=1; lowest remaining list bit is presented. A transfer completes
//   only when xfer_valid & mem_ready; the bit is cleared and the next one is presented
//   the following cycle. mem_ready low: outputs hold stable.
//  Ordering: ascending register index, ascending address; i = transfer number 0..N-1.
//   LDM/STM/POP: xfer_offset = 4*i.  PUSH: xfer_offset = 4*i - 4*N.
//  Writeback (WB cycle): wb_offset = +4*N (LDM/STM/POP), -4*N (PUSH).
//   wb_valid=1 except: N=0, or LDM with Rn in list (loaded value wins).
//   STM with Rn in list: stored value is original Rn; writeback still occurs.
//  pc_loaded=1 in WB cycle only for POP with hw[8]=1.
//  N=0 (UNPREDICTABLE encoding): no transfers, no writeback; done after 1 cycle.
//  Reset mid-sequence: abort immediately; outputs to reset values, no writeback.
//  Latency: start -> first xfer_valid 1 cycle; N transfers with mem_ready=1 ->
//   done N+1 cycles after start.
// TESTING
//  PUSH {R0,R2,LR} (hw 0xB505), ready=1 -> regs 0,2,14 offsets -12,-8,-4; wb -12; done cyc 4
//  POP {R1,PC} (hw 0xBD02) -> regs 1,15 offsets 0,4, is_load=1; wb +8; pc_loaded=1 with done
//  LDM R1!,{R1,R3} (hw 0xC90A) -> regs 1,3 offsets 0,4; wb_valid=0; STM R1!,{R1} wb +4
//  STM R0!,{R0..R7} (hw 0xC0FF), mem_ready low on 2nd and 5th -> outputs hold; 8 xfers, done
//  hw 0xC000 (empty list) -> no xfer_valid, wb_valid=0, done 1 cycle after start
//  rst_n low during 3rd transfer -> all outputs 0 same cycle; new start accepted after release

Source files
------------

// File: rtl/multiple_transfer_sequencer.sv
// Sequences Thumb LDM/STM/PUSH/POP into one register transfer per cycle,
// followed by a single base-register writeback cycle.
module multiple_transfer_sequencer #(
   parameter int unsigned OFFSET_W = 7,
   parameter logic [3:0]  SP_INDEX = 4'd13
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         instruction_from_mem,
   input  logic                is32_from_stage1,
   input  logic                multiple_stable_odd,
   input  logic                issue_valid,
   input  logic                mem_ready,
   output logic                busy,
   output logic                stall_fetch,
   output logic                xfer_valid,
   output logic [3:0]          xfer_reg,
   output logic                xfer_is_load,
   output logic [3:0]          xfer_base_reg,
   output logic [OFFSET_W-1:0] xfer_offset,
   output logic                wb_valid,
   output logic [OFFSET_W-1:0] wb_offset,
   output logic                pc_loaded,
   output logic                done
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

   state_t              state_q, state_d;
   logic [8:0]          list_q, list_d;
   logic [3:0]          hi_reg_q, hi_reg_d;
   logic                wb_en_q, wb_en_d;
   logic [OFFSET_W-1:0] wb_off_q, wb_off_d;
   logic                pc_q, pc_d;
   logic                busy_q, busy_d;
   logic                xfer_valid_q, xfer_valid_d;
   logic [3:0]          xfer_reg_q, xfer_reg_d;
   logic                xfer_is_load_q, xfer_is_load_d;
   logic [3:0]          xfer_base_reg_q, xfer_base_reg_d;
   logic [OFFSET_W-1:0] xfer_offset_q, xfer_offset_d;
   logic                wb_valid_q, wb_valid_d;
   logic [OFFSET_W-1:0] wb_offset_q, wb_offset_d;
   logic                pc_loaded_q, pc_loaded_d;
   logic                done_q, done_d;

   // Index of the lowest set bit in a 9-bit register list.
   function automatic logic [3:0] low_idx(input logic [8:0] v);
      low_idx = 4'd0;
      for (int b = 8; b >= 0; b--) begin
         if (v[b]) low_idx = 4'(b);
      end
   endfunction

   // List bit 8 stands for R14 (PUSH) or R15 (POP).
   function automatic logic [3:0] reg_of(input logic [3:0] idx, input logic [3:0] hi);
      reg_of = (idx == 4'd8) ? hi : idx;
   endfunction

   logic [15:0]         hw_c;
   logic [7:0]          list8_c;
   logic                pushpop_c, load_c, push_c, start_c, rn_in_list_c;
   logic [8:0]          list_c, rem_c;
   logic [3:0]          base_c, n_c, hi_c;
   logic [OFFSET_W-1:0] four_n_c, neg_four_n_c;
   logic                unused_c;

   assign hw_c         = instruction_from_mem[31:16];
   assign unused_c     = ^instruction_from_mem[15:0];
   assign list8_c      = hw_c[7:0];
   assign pushpop_c    = (hw_c[15:12] == 4'b1011) && (hw_c[10:9] == 2'b10);
   assign load_c       = hw_c[11];
   assign push_c       = pushpop_c & ~load_c;
   assign list_c       = {pushpop_c & hw_c[8], list8_c};
   assign base_c       = pushpop_c ? SP_INDEX : {1'b0, hw_c[10:8]};
   assign hi_c         = load_c ? 4'd15 : 4'd14;
   assign rn_in_list_c = ~pushpop_c & list8_c[hw_c[10:8]];
   assign four_n_c     = OFFSET_W'({n_c, 2'b00});
   assign neg_four_n_c = OFFSET_W'(0) - four_n_c;
   assign rem_c        = list_q & (list_q - 9'd1);
   assign start_c      = (state_q == S_IDLE) & issue_valid & multiple_stable_odd
                         & ~is32_from_stage1;

   always_comb begin
      n_c = 4'd0;
      for (int b = 0; b < 9; b++) n_c = n_c + 4'(list_c[b]);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d         = state_q;
      list_d          = list_q;
      hi_reg_d        = hi_reg_q;
      wb_en_d         = wb_en_q;
      wb_off_d        = wb_off_q;
      pc_d            = pc_q;
      busy_d          = busy_q;
      xfer_valid_d    = xfer_valid_q;
      xfer_reg_d      = xfer_reg_q;
      xfer_is_load_d  = xfer_is_load_q;
      xfer_base_reg_d = xfer_base_reg_q;
      xfer_offset_d   = xfer_offset_q;
      wb_valid_d      = wb_valid_q;
      wb_offset_d     = wb_offset_q;
      pc_loaded_d     = pc_loaded_q;
      done_d          = done_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_c) begin
               list_d   = list_c;
               hi_reg_d = hi_c;
               wb_en_d  = (n_c != 4'd0) & ~(load_c & rn_in_list_c);
               wb_off_d = push_c ? neg_four_n_c : four_n_c;
               pc_d     = pushpop_c & load_c & hw_c[8];
               busy_d   = 1'b1;
               if (n_c != 4'd0) begin
                  state_d         = S_XFER;
                  xfer_valid_d    = 1'b1;
                  xfer_reg_d      = reg_of(low_idx(list_c), hi_c);
                  xfer_is_load_d  = load_c;
                  xfer_base_reg_d = base_c;
                  xfer_offset_d   = push_c ? neg_four_n_c : OFFSET_W'(0);
               end else begin
                  // Empty list: straight to a writeback cycle that writes nothing.
                  state_d     = S_WB;
                  wb_valid_d  = 1'b0;
                  wb_offset_d = OFFSET_W'(0);
                  pc_loaded_d = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
         S_XFER: begin
            if (xfer_valid_q && mem_ready) begin
               list_d = rem_c;
               if (rem_c != 9'd0) begin
                  xfer_reg_d    = reg_of(low_idx(rem_c), hi_reg_q);
                  xfer_offset_d = xfer_offset_q + OFFSET_W'(4);
               end else begin
                  state_d         = S_WB;
                  xfer_valid_d    = 1'b0;
                  xfer_reg_d      = 4'd0;
                  xfer_is_load_d  = 1'b0;
                  xfer_base_reg_d = 4'd0;
                  xfer_offset_d   = OFFSET_W'(0);
                  wb_valid_d      = wb_en_q;
                  wb_offset_d     = wb_off_q;
                  pc_loaded_d     = pc_q;
                  done_d          = 1'b1;
               end
            end
         end
         S_WB: begin
            state_d     = S_IDLE;
            list_d      = 9'd0;
            busy_d      = 1'b0;
            wb_valid_d  = 1'b0;
            wb_offset_d = OFFSET_W'(0);
            pc_loaded_d = 1'b0;
            done_d      = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         list_q          <= 9'd0;
         hi_reg_q        <= 4'd0;
         wb_en_q         <= 1'b0;
         wb_off_q        <= OFFSET_W'(0);
         pc_q            <= 1'b0;
         busy_q          <= 1'b0;
         xfer_valid_q    <= 1'b0;
         xfer_reg_q      <= 4'd0;
         xfer_is_load_q  <= 1'b0;
         xfer_base_reg_q <= 4'd0;
         xfer_offset_q   <= OFFSET_W'(0);
         wb_valid_q      <= 1'b0;
         wb_offset_q     <= OFFSET_W'(0);
         pc_loaded_q     <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         list_q          <= list_d;
         hi_reg_q        <= hi_reg_d;
         wb_en_q         <= wb_en_d;
         wb_off_q        <= wb_off_d;
         pc_q            <= pc_d;
         busy_q          <= busy_d;
         xfer_valid_q    <= xfer_valid_d;
         xfer_reg_q      <= xfer_reg_d;
         xfer_is_load_q  <= xfer_is_load_d;
         xfer_base_reg_q <= xfer_base_reg_d;
         xfer_offset_q   <= xfer_offset_d;
         wb_valid_q      <= wb_valid_d;
         wb_offset_q     <= wb_offset_d;
         pc_loaded_q     <= pc_loaded_d;
         done_q          <= done_d;
      end
   end

   assign busy          = busy_q;
   assign stall_fetch   = start_c | busy_q;
   assign xfer_valid    = xfer_valid_q;
   assign xfer_reg      = xfer_reg_q;
   assign xfer_is_load  = xfer_is_load_q;
   assign xfer_base_reg = xfer_base_reg_q;
   assign xfer_offset   = xfer_offset_q;
   assign wb_valid      = wb_valid_q;
   assign wb_offset     = wb_offset_q;
   assign pc_loaded     = pc_loaded_q;
   assign done          = done_q;

endmodule
